// File: rtl/rx_fsm.sv
// rx_fsm: UART receiver with mid-bit sampling, optional parity and stop-bit checking
module rx_fsm #(
    parameter int divisor     = 1000000,
    parameter int rx_num_bits = 8,
    parameter int parity      = 0
) (
    input  logic       clk,
    input  logic       RSTn,
    input  logic       RX,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(divisor);
    localparam logic [CW-1:0] half_cnt = CW'(divisor / 2 - 1);
    localparam logic [CW-1:0] last_cnt = CW'(divisor - 1);
    localparam logic [2:0] last_idx = 3'(rx_num_bits - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t state, state_n;
    logic s1, rx_s, rx_p;
    logic [CW-1:0] bit_cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] sh, sh_n, dout_n;
    logic bad, bad_n, valid_n, perr_n, ferr_n;

    assign busy = state != IDLE;

    // synchroniser, edge history, state and registered outputs
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            s1 <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
            state <= IDLE;
            bit_cnt <= '0;
            idx <= '0;
            sh <= '0;
            bad <= 1'b0;
            data_out <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            s1 <= RX;
            rx_s <= s1;
            rx_p <= rx_s;
            state <= state_n;
            bit_cnt <= cnt_n;
            idx <= idx_n;
            sh <= sh_n;
            bad <= bad_n;
            data_out <= dout_n;
            data_valid <= valid_n;
            parity_err <= perr_n;
            frame_err <= ferr_n;
        end
    end

    // next-state: count cycles within a bit and act on the sampling point of each state
    always_comb begin
        state_n = state;
        cnt_n = bit_cnt + 1'b1;
        idx_n = idx;
        sh_n = sh;
        bad_n = bad;
        dout_n = data_out;
        valid_n = 1'b0;
        perr_n = 1'b0;
        ferr_n = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (rx_p && !rx_s) state_n = START;
            end
            START: if (bit_cnt == half_cnt) begin
                cnt_n = '0;
                idx_n = '0;
                bad_n = 1'b0;
                state_n = rx_s ? IDLE : DATA;
            end
            DATA: if (bit_cnt == last_cnt) begin
                cnt_n = '0;
                sh_n[idx] = rx_s;
                idx_n = idx + 1'b1;
                if (idx == last_idx) state_n = (parity != 0) ? PARITY : STOP;
            end
            PARITY: if (bit_cnt == last_cnt) begin
                cnt_n = '0;
                bad_n = rx_s ^ (^sh) ^ (parity == 2);
                state_n = STOP;
            end
            STOP: if (bit_cnt == last_cnt) begin
                cnt_n = '0;
                dout_n = sh;
                valid_n = rx_s & ~bad;
                perr_n = bad;
                ferr_n = ~rx_s;
                bad_n = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rx_fsm.sv
// tb_rx_fsm: directed frame vectors over three receiver configurations
module tb_rx_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx [3];
    logic [7:0] dout [3];
    logic dv [3];
    logic pe [3];
    logic fe [3];
    logic bsy [3];
    int vcnt [3];
    int pcnt [3];
    int fcnt [3];
    logic [7:0] last_d [3];
    logic [7:0] prev_d [3];
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    rx_fsm #(.divisor(16), .rx_num_bits(8), .parity(0)) u0 (
        .clk(clk), .RSTn(rst_n), .RX(rx[0]), .data_out(dout[0]), .data_valid(dv[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .busy(bsy[0]));
    rx_fsm #(.divisor(16), .rx_num_bits(8), .parity(1)) u1 (
        .clk(clk), .RSTn(rst_n), .RX(rx[1]), .data_out(dout[1]), .data_valid(dv[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .busy(bsy[1]));
    rx_fsm #(.divisor(16), .rx_num_bits(7), .parity(2)) u2 (
        .clk(clk), .RSTn(rst_n), .RX(rx[2]), .data_out(dout[2]), .data_valid(dv[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .busy(bsy[2]));

    // strobe counters and log of the last two words delivered with data_valid
    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (dv[c]) begin
                vcnt[c] <= vcnt[c] + 1;
                prev_d[c] <= last_d[c];
                last_d[c] <= dout[c];
            end
            if (pe[c]) pcnt[c] <= pcnt[c] + 1;
            if (fe[c]) fcnt[c] <= fcnt[c] + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        else passed++;
    endtask

    task automatic bitt(input int ch, input logic b, input int n);
        rx[ch] = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input int ch, input logic [7:0] d, input int nb, input bit hp, input logic pb, input logic sb);
        bitt(ch, 1'b0, 16);
        for (int i = 0; i < nb; i++) bitt(ch, d[i], 16);
        if (hp) bitt(ch, pb, 16);
        bitt(ch, sb, 16);
        rx[ch] = 1'b1;
    endtask

    typedef struct {
        int ch;
        logic [7:0] d;
        int nb;
        bit hp;
        logic pb;
        logic sb;
        int hold;
        int ev;
        int ep;
        int ef;
        logic [7:0] ed;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int v0, p0, f0, n;
        for (int c = 0; c < 3; c++) begin
            rx[c] = 1'b1;
            vcnt[c] = 0;
            pcnt[c] = 0;
            fcnt[c] = 0;
            last_d[c] = '0;
            prev_d[c] = '0;
        end
        vecs[0] = '{0, 8'h55, 8, 1'b0, 1'b0, 1'b1, 0, 1, 0, 0, 8'h55};
        vecs[1] = '{1, 8'hA3, 8, 1'b1, 1'b0, 1'b1, 0, 1, 0, 0, 8'hA3};
        vecs[2] = '{1, 8'hA3, 8, 1'b1, 1'b1, 1'b1, 0, 0, 1, 0, 8'hA3};
        vecs[3] = '{0, 8'h3C, 8, 1'b0, 1'b0, 1'b0, 3, 0, 0, 1, 8'h3C};
        vecs[4] = '{0, 8'h81, 8, 1'b0, 1'b0, 1'b1, 0, 1, 0, 0, 8'h81};
        vecs[5] = '{1, 8'h5A, 8, 1'b1, 1'b1, 1'b0, 0, 0, 1, 1, 8'h5A};
        vecs[6] = '{2, 8'h7F, 7, 1'b1, 1'b0, 1'b1, 0, 1, 0, 0, 8'h7F};
        vecs[7] = '{2, 8'h00, 7, 1'b1, 1'b1, 1'b1, 0, 1, 0, 0, 8'h00};
        vecs[8] = '{2, 8'h2A, 7, 1'b1, 1'b1, 1'b1, 0, 0, 1, 0, 8'h2A};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", int'(dout[0]), 0);
        chk("rst_valid", int'(dv[0]), 0);
        chk("rst_perr", int'(pe[0]), 0);
        chk("rst_ferr", int'(fe[0]), 0);
        chk("rst_busy", int'(bsy[0]), 0);
        rst_n = 1'b1;
        bitt(0, 1'b1, 4);

        for (int i = 0; i < 9; i++) begin
            n = vecs[i].ch;
            v0 = vcnt[n];
            p0 = pcnt[n];
            f0 = fcnt[n];
            frame(n, vecs[i].d, vecs[i].nb, vecs[i].hp, vecs[i].pb, vecs[i].sb);
            if (vecs[i].hold > 0) begin
                bitt(n, 1'b0, 16 * vecs[i].hold);
                chk($sformatf("v%0d_busy_while_low", i), int'(bsy[n]), 0);
                rx[n] = 1'b1;
            end
            bitt(n, 1'b1, 4);
            chk($sformatf("v%0d_valid", i), vcnt[n] - v0, vecs[i].ev);
            chk($sformatf("v%0d_perr", i), pcnt[n] - p0, vecs[i].ep);
            chk($sformatf("v%0d_ferr", i), fcnt[n] - f0, vecs[i].ef);
            chk($sformatf("v%0d_data_out", i), int'(dout[n]), int'(vecs[i].ed));
        end

        v0 = vcnt[2];
        p0 = pcnt[2];
        f0 = fcnt[2];
        frame(2, 8'h7F, 7, 1'b1, 1'b0, 1'b1);
        frame(2, 8'h00, 7, 1'b1, 1'b1, 1'b1);
        bitt(2, 1'b1, 4);
        chk("b2b_valid_count", vcnt[2] - v0, 2);
        chk("b2b_err_count", (pcnt[2] - p0) + (fcnt[2] - f0), 0);
        chk("b2b_first_word", int'(prev_d[2]), 8'h7F);
        chk("b2b_second_word", int'(last_d[2]), 8'h00);

        v0 = vcnt[0] + pcnt[0] + fcnt[0];
        n = 0;
        rx[0] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k == 4) rx[0] = 1'b1;
            @(negedge clk);
            if (bsy[0]) n++;
            @(posedge clk);
            #1;
        end
        chk("glitch_busy_cycles", n, 8);
        chk("glitch_strobes", vcnt[0] + pcnt[0] + fcnt[0] - v0, 0);

        v0 = vcnt[0] + pcnt[0] + fcnt[0];
        bitt(0, 1'b0, 16);
        bitt(0, 1'b1, 48);
        rst_n = 1'b0;
        #2;
        chk("midrst_data_out", int'(dout[0]), 0);
        chk("midrst_busy", int'(bsy[0]), 0);
        chk("midrst_valid", int'(dv[0]), 0);
        bitt(0, 1'b1, 3);
        rst_n = 1'b1;
        bitt(0, 1'b1, 160);
        chk("midrst_no_strobe", vcnt[0] + pcnt[0] + fcnt[0] - v0, 0);
        chk("midrst_data_kept", int'(dout[0]), 0);
        v0 = vcnt[0];
        frame(0, 8'h12, 8, 1'b0, 1'b0, 1'b1);
        bitt(0, 1'b1, 4);
        chk("post_rst_valid", vcnt[0] - v0, 1);
        chk("post_rst_data_out", int'(dout[0]), 8'h12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
